sror_update_engine: RTL and testbench

Sequential update scheduler for the parallel SROr (sequential random-order) Boolean-network simulator. It owns the network state register, drives `current_state` into the combinational `network_logic` block, and takes back `next_state`. Each cycle it commits exactly one element. Within a round every element is updated exactly once, in a pseudo-random order. The block runs a programmed number of rounds, then signals completion.

---
 rtl/sror_pkg.sv | 16 +
 rtl/sror_update_engine_pick_free.sv | 37 +++
 rtl/sror_update_engine.sv | 122 ++++++++++++
 tb/tb_sror_update_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sror_pkg.sv
// Shared types and constants for the SROr update engine.
package sror_pkg;

  // Scheduler states: idle, committing elements, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sror_state_t;

  // Galois feedback mask for the order-generating LFSR.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  // Substituted for an all-zero seed, which would lock the LFSR.
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/sror_update_engine_pick_free.sv
// Picks the first not-yet-updated element at or after position r (wrapping).
// Flags when that element is the last free one of the round.
module sror_pick_free #(
  parameter int RULES = 61,
  parameter int IDX_W = $clog2(RULES)
) (
  input  logic [RULES-1:0] mask,
  input  logic [IDX_W-1:0] r,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [RULES-1:0]   free;
  logic [2*RULES-1:0] free_dbl;
  logic [RULES-1:0]   free_rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  assign free     = ~mask;
  // Rotate so that bit 0 of free_rot corresponds to element r.
  assign free_dbl = {free, free};
  assign free_rot = free_dbl[r +: RULES];

  // Priority encode: lowest free position in rotated order wins.
  always_comb begin
    off = '0;
    for (int j = RULES - 1; j >= 0; j--) begin
      if (free_rot[j]) off = IDX_W'(j);
    end
  end

  // Un-rotate back to an absolute element index.
  assign sum  = {1'b0, r} + {1'b0, off};
  assign idx  = (sum >= (IDX_W+1)'(RULES)) ? IDX_W'(sum - (IDX_W+1)'(RULES)) : sum[IDX_W-1:0];
  assign last = (free != '0) && ((free & (free - RULES'(1))) == '0);

endmodule

// File: rtl/sror_update_engine.sv
// Sequential random-order update scheduler: one element committed per cycle,
// each element exactly once per round, for a programmed number of rounds.
`ifndef RULES
`define RULES 61
`endif
module sror_update_engine
  import sror_pkg::*;
#(
  parameter int RULES   = `RULES,
  parameter int LFSR_W  = 16,
  parameter int ROUND_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     hold,
  input  logic [RULES-1:0]         init_state,
  input  logic [ROUND_W-1:0]       num_rounds,
  input  logic [LFSR_W-1:0]        seed,
  input  logic [RULES-1:0]         next_state,
  output logic [RULES-1:0]         current_state,
  output logic                     busy,
  output logic                     done,
  output logic                     update_valid,
  output logic [$clog2(RULES)-1:0] update_idx,
  output logic [ROUND_W-1:0]       round_count
);

  localparam int IDX_W = $clog2(RULES);

  sror_state_t        state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [RULES-1:0]   mask_q, mask_d;
  logic [RULES-1:0]   cur_q, cur_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [ROUND_W-1:0] nrounds_q, nrounds_d;

  logic [IDX_W-1:0]   r;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_last;
  logic [LFSR_W-1:0]  lfsr_step;
  logic [LFSR_W-1:0]  seed_eff;
  logic [ROUND_W-1:0] round_inc;
  logic               commit;

  assign r         = IDX_W'(lfsr_q % LFSR_W'(RULES));
  assign lfsr_step = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_W'(LFSR_TAPS) : '0);
  assign seed_eff  = (seed == '0) ? LFSR_W'(DEFAULT_SEED) : seed;
  assign round_inc = round_q + ROUND_W'(1);
  assign commit    = (state_q == RUN) && !hold;

  sror_pick_free #(.RULES(RULES), .IDX_W(IDX_W)) u_pick (
    .mask (mask_q),
    .r    (r),
    .idx  (pick_idx),
    .last (pick_last)
  );

  // Next-state: load on start, commit one element per unheld RUN cycle.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    mask_d    = mask_q;
    cur_d     = cur_q;
    round_d   = round_q;
    nrounds_d = nrounds_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d     = init_state;
          mask_d    = '0;
          round_d   = '0;
          lfsr_d    = seed_eff;
          nrounds_d = num_rounds;
          state_d   = (num_rounds == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          cur_d[pick_idx] = next_state[pick_idx];
          lfsr_d          = lfsr_step;
          if (pick_last) begin
            mask_d  = '0;
            round_d = round_inc;
            if (round_inc == nrounds_q) state_d = DONE;
          end else begin
            mask_d[pick_idx] = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_W'(DEFAULT_SEED);
      mask_q    <= '0;
      cur_q     <= '0;
      round_q   <= '0;
      nrounds_q <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      mask_q    <= mask_d;
      cur_q     <= cur_d;
      round_q   <= round_d;
      nrounds_q <= nrounds_d;
    end
  end

  assign current_state = cur_q;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign update_valid  = commit;
  assign update_idx    = pick_idx;
  assign round_count   = round_q;

endmodule

// File: tb/tb_sror_update_engine.sv
// Scoreboard bench: a software SROr model fills an expected-commit queue at
// each start; a negedge monitor pops and compares on every update_valid.
module tb_sror_update_engine;

  typedef struct {
    int          idx;
    logic [63:0] st;
  } item_t;

  logic clk;
  logic rst4, rst61;
  logic start, hold;
  logic [63:0] init_bus;
  logic [15:0] nr, seed;
  int cur;

  logic [3:0]  cs4, ns4;
  logic [1:0]  idx4;
  logic [60:0] cs61, ns61;
  logic [5:0]  idx61;
  logic [63:0] ns61_w;
  logic        busy4, done4, uv4, busy61, done61, uv61;
  logic [15:0] rc4, rc61;

  logic [63:0] cs_sel;
  logic [5:0]  idx_sel;
  logic        uv_sel, done_sel, busy_sel;
  logic [15:0] rc_sel;

  item_t exp_q[$];
  int    obs_q[$];
  int    ref_q[$];
  logic [63:0] exp_cs;
  bit    mon_en;
  int    total, bad;

  // Element update rules: 4-element net inverts every bit; 61-element net
  // uses a fixed neighbour rule so that update order matters.
  function automatic logic [63:0] nf(int n, logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (n == 4) r[i] = ~s[i];
      else r[i] = s[(i+1)%n] ^ (s[(i+n-1)%n] & ~s[(i+7)%n]) ^ ((i % 5) == 0);
    end
    return r;
  endfunction

  assign ns4    = ~cs4;
  assign ns61_w = nf(61, 64'(cs61));
  assign ns61   = ns61_w[60:0];

  sror_update_engine #(.RULES(4)) u4 (
    .clk(clk), .rst(rst4), .start(start && cur == 0), .hold(hold),
    .init_state(init_bus[3:0]), .num_rounds(nr), .seed(seed),
    .next_state(ns4), .current_state(cs4), .busy(busy4), .done(done4),
    .update_valid(uv4), .update_idx(idx4), .round_count(rc4)
  );

  sror_update_engine #(.RULES(61)) u61 (
    .clk(clk), .rst(rst61), .start(start && cur == 1), .hold(hold),
    .init_state(init_bus[60:0]), .num_rounds(nr), .seed(seed),
    .next_state(ns61), .current_state(cs61), .busy(busy61), .done(done61),
    .update_valid(uv61), .update_idx(idx61), .round_count(rc61)
  );

  assign cs_sel   = (cur == 0) ? 64'(cs4) : 64'(cs61);
  assign idx_sel  = (cur == 0) ? 6'(idx4) : idx61;
  assign uv_sel   = (cur == 0) ? uv4 : uv61;
  assign done_sel = (cur == 0) ? done4 : done61;
  assign busy_sel = (cur == 0) ? busy4 : busy61;
  assign rc_sel   = (cur == 0) ? rc4 : rc61;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Software SROr: per round, walk the LFSR order, skip used elements.
  function automatic void ref_fill(int n, logic [63:0] init, int rounds,
                                   logic [15:0] sd, output logic [63:0] fin);
    logic [63:0] st, nx;
    bit          used[64];
    logic [15:0] l;
    int          p;
    item_t       it;
    st = init;
    l  = (sd == 16'h0) ? 16'hACE1 : sd;
    for (int rd = 0; rd < rounds; rd++) begin
      for (int i = 0; i < 64; i++) used[i] = 0;
      for (int c = 0; c < n; c++) begin
        p = int'(l % 16'(n));
        while (used[p]) p = (p + 1) % n;
        nx    = nf(n, st);
        st[p] = nx[p];
        used[p] = 1;
        it.idx = p;
        it.st  = st;
        exp_q.push_back(it);
        l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      end
    end
    fin = st;
  endfunction

  // Monitor: state must match expected after all earlier commits; each commit
  // must match the next scoreboard entry.
  always @(negedge clk) begin
    if (mon_en) begin
      item_t it;
      chk("state", cs_sel, exp_cs);
      if (uv_sel) begin
        if (exp_q.size() == 0) begin
          chk("extra_commit", 64'(idx_sel), 64'hFFFF);
        end else begin
          it = exp_q.pop_front();
          chk("commit_idx", 64'(idx_sel), 64'(it.idx));
          exp_cs = it.st;
          obs_q.push_back(int'(idx_sel));
        end
      end
    end
  end

  task automatic run(input int inst, input logic [63:0] init, input int rounds,
                     input logic [15:0] sd, input int hold_pct, input int hold_at,
                     input bit poke_start);
    int n, nexp, holds;
    bit seen;
    logic [63:0] fin;
    n = (inst == 0) ? 4 : 61;
    cur = inst;
    exp_q.delete();
    obs_q.delete();
    ref_fill(n, init, rounds, sd, fin);
    nexp = n * rounds;
    @(posedge clk); #1;
    start = 1; init_bus = init; nr = 16'(rounds); seed = sd; hold = 0;
    @(posedge clk); #1;
    start = 0; exp_cs = init; mon_en = 1; holds = 0; seen = 0;
    for (int k = 1; k <= 2 * nexp + 40 && !seen; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      hold = (hold_at > 0 && k >= hold_at && k < hold_at + 3) ||
             (int'($urandom_range(99)) < hold_pct);
      if (poke_start && k == 3) begin start = 1; init_bus = ~init; nr = 16'd5; end
      if (poke_start && k == 4) start = 0;
      @(negedge clk);
      if (done_sel) begin
        seen = 1;
        chk("done_cycle", 64'(k), 64'(nexp + holds + 1));
        chk("busy_in_done", 64'(busy_sel), 64'h0);
        chk("final_state", cs_sel, fin);
        chk("round_count", 64'(rc_sel), 64'(rounds));
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
      end else if (hold) begin
        holds++;
      end
    end
    hold = 0; start = 0;
    #1 mon_en = 0;
    if (!seen) chk("done_timeout", 64'h0, 64'h1);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done_sel), 64'h0);
  endtask

  initial begin
    logic [63:0] fin;
    bit          saw_done;
    logic [3:0]  m;
    total = 0; bad = 0; mon_en = 0; cur = 0;
    rst4 = 1; rst61 = 1; start = 0; hold = 0;
    init_bus = '0; nr = '0; seed = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      cur = i; #1;
      chk("rst_state", cs_sel, 64'h0);
      chk("rst_busy", 64'(busy_sel), 64'h0);
      chk("rst_done", 64'(done_sel), 64'h0);
      chk("rst_rc", 64'(rc_sel), 64'h0);
      chk("rst_uv", 64'(uv_sel), 64'h0);
    end
    rst4 = 0; rst61 = 0;

    // Full flip, one round.
    run(0, 64'h0, 1, 16'hACE1, 0, 0, 0);
    chk("flip1_final", cs_sel, 64'hF);
    ref_q = obs_q;

    // Two rounds flip back; each round visits all four elements.
    run(0, 64'h0, 2, 16'hACE1, 0, 0, 0);
    chk("flip2_final", cs_sel, 64'h0);
    chk("flip2_count", 64'(obs_q.size()), 64'd8);
    for (int rd = 0; rd < 2; rd++) begin
      m = '0;
      for (int c = 0; c < 4 && rd * 4 + c < obs_q.size(); c++) m[obs_q[rd*4+c]] = 1'b1;
      chk("round_perm", 64'(m), 64'hF);
    end

    // Zero seed behaves as the default seed.
    run(0, 64'h0, 1, 16'h0000, 0, 0, 0);
    chk("seed0_len", 64'(obs_q.size()), 64'(ref_q.size()));
    for (int i = 0; i < 4 && i < obs_q.size() && i < ref_q.size(); i++)
      chk("seed0_order", 64'(obs_q[i]), 64'(ref_q[i]));

    // Zero rounds.
    run(0, 64'hA, 0, 16'h1357, 0, 0, 0);
    chk("zero_rounds_state", cs_sel, 64'hA);
    chk("zero_rounds_commits", 64'(obs_q.size()), 64'h0);

    // Hold for three cycles plus a start poke mid-run; order must match no-hold.
    run(0, 64'h5, 2, 16'h2468, 0, 0, 0);
    ref_q = obs_q;
    run(0, 64'h5, 2, 16'h2468, 0, 3, 1);
    chk("hold_len", 64'(obs_q.size()), 64'(ref_q.size()));
    for (int i = 0; i < obs_q.size() && i < ref_q.size(); i++)
      chk("hold_order", 64'(obs_q[i]), 64'(ref_q[i]));

    // Reset mid-run.
    cur = 0;
    exp_q.delete(); obs_q.delete();
    ref_fill(4, 64'h0, 2, 16'h5A5A, fin);
    @(posedge clk); #1;
    start = 1; init_bus = '0; nr = 16'd2; seed = 16'h5A5A;
    @(posedge clk); #1;
    start = 0; exp_cs = '0; mon_en = 1;
    for (int w = 0; w < 20 && obs_q.size() < 2; w++) begin @(negedge clk); #1; end
    chk("rst_mid_commits", 64'(obs_q.size()), 64'd2);
    rst4 = 1; mon_en = 0; #1;
    chk("rst_mid_state", cs_sel, 64'h0);
    chk("rst_mid_busy", 64'(busy_sel), 64'h0);
    chk("rst_mid_rc", 64'(rc_sel), 64'h0);
    chk("rst_mid_uv", 64'(uv_sel), 64'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst4 = 0;
    saw_done = 0;
    repeat (12) begin @(negedge clk); saw_done |= done_sel; end
    chk("rst_mid_no_done", 64'(saw_done), 64'h0);
    chk("rst_mid_state_after", cs_sel, 64'h0);

    // Random small-network runs with random hold.
    for (int t = 0; t < 6; t++)
      run(0, 64'($urandom_range(15)), int'($urandom_range(1, 3)),
          16'($urandom), 20, 0, t[0]);

    // Full 61-element network: two seed elements high, 20 rounds, fixed seed.
    run(1, 64'h3, 20, 16'h1234, 0, 0, 0);
    for (int t = 0; t < 3; t++)
      run(1, {$urandom, $urandom} & 64'h1FFF_FFFF_FFFF_FFFF,
          int'($urandom_range(1, 2)), 16'($urandom), 10, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
